sram_like_arbiter: RTL and testbench

Parametrised N-to-1 arbiter for the sram-like bus (req / addr_ok / data_ok). It merges the core's request channels onto one downstream memory port, such as the bridge in front of the AXI interface. Channel 0 is the instruction fetch port and channel 1 is the data port; further channels (e.g. a future TLB walker) attach as extra indices. An in-order outstanding-transaction queue routes each data_ok/rdata response back to the channel that issued the request.

---
 rtl/sram_like_arbiter.sv | 178 +++++++++++++++++
 tb/tb_sram_like_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_arbiter.sv
// N-to-1 sram-like bus arbiter with an in-order queue that routes responses back to the issuing channel.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin grants; fixed priority (highest index wins) otherwise.
module sram_like_arbiter #(
    parameter int NCH   = 2,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NCH-1:0]        m_req,
    input  logic [NCH-1:0]        m_wr,
    input  logic [2*NCH-1:0]      m_size,
    input  logic [4*NCH-1:0]      m_wstrb,
    input  logic [32*NCH-1:0]     m_addr,
    input  logic [32*NCH-1:0]     m_wdata,
    output logic [NCH-1:0]        m_addr_ok,
    output logic [NCH-1:0]        m_data_ok,
    output logic [31:0]           m_rdata,
    output logic                  s_req,
    output logic                  s_wr,
    output logic [1:0]            s_size,
    output logic [3:0]            s_wstrb,
    output logic [31:0]           s_addr,
    output logic [31:0]           s_wdata,
    input  logic                  s_addr_ok,
    input  logic                  s_data_ok,
    input  logic [31:0]           s_rdata,
    output logic [$clog2(DEPTH):0] outstanding
);

    localparam int IDW = ($clog2(NCH) > 1) ? $clog2(NCH) : 1;
    localparam int PW  = $clog2(DEPTH);

    // Handshake: s_req stays asserted with stable fields until s_addr_ok; m_addr_ok
    // and m_data_ok are single-cycle strobes in the cycle the downstream accepts/responds.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t         state, state_next;
    logic [IDW-1:0] lock_id, lock_id_next;

    logic [IDW-1:0] q_mem [DEPTH];
    logic [PW-1:0]  head, tail;
    logic [PW:0]    count;

    logic [IDW-1:0] grant;
    logic           grant_valid;
    logic           req_sel, full, empty, accept, pop, locked;
    int             gi;

`ifdef ARB_ROUND_ROBIN_EN
    logic [IDW-1:0] rr_ptr;
    int             rr_idx;
`endif

    assign full   = (count == (PW+1)'(DEPTH));
    assign empty  = (count == '0);
    assign locked = (state == ST_LOCKED);

    // Grant selection; a pending request must not be swapped, so the lock wins.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        rr_idx      = 0;
`endif
        if (locked) begin
            grant       = lock_id;
            grant_valid = 1'b1;
        end else begin
`ifdef ARB_ROUND_ROBIN_EN
            for (int k = NCH - 1; k >= 0; k--) begin
                rr_idx = (int'(rr_ptr) + k) % NCH;
                if (m_req[rr_idx]) begin
                    grant       = IDW'(rr_idx);
                    grant_valid = 1'b1;
                end
            end
`else
            for (int i = 0; i < NCH; i++) begin
                if (m_req[i]) begin
                    grant       = IDW'(i);
                    grant_valid = 1'b1;
                end
            end
`endif
        end
    end

    assign gi      = int'(grant);
    assign req_sel = grant_valid & m_req[grant];
    assign s_req   = req_sel & ~full & resetn;
    assign accept  = s_req & s_addr_ok;
    assign pop     = s_data_ok & ~empty & resetn;

    // Lock FSM: state register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            lock_id <= '0;
        end else begin
            state   <= state_next;
            lock_id <= lock_id_next;
        end
    end

    // Lock FSM: next state
    always_comb begin
        state_next   = ST_IDLE;
        lock_id_next = lock_id;
        if (s_req && !s_addr_ok) begin
            state_next   = ST_LOCKED;
            lock_id_next = grant;
        end
    end

    // Output decode
    always_comb begin
        m_addr_ok   = '0;
        m_data_ok   = '0;
        m_rdata     = '0;
        s_wr        = 1'b0;
        s_size      = '0;
        s_wstrb     = '0;
        s_addr      = '0;
        s_wdata     = '0;
        outstanding = '0;
        if (accept)
            m_addr_ok = NCH'(1) << grant;
        if (pop) begin
            m_data_ok = NCH'(1) << q_mem[head];
            m_rdata   = s_rdata;
        end
        if (resetn) begin
            s_wr        = m_wr[grant];
            s_size      = m_size[gi*2 +: 2];
            s_wstrb     = m_wstrb[gi*4 +: 4];
            s_addr      = m_addr[gi*32 +: 32];
            s_wdata     = m_wdata[gi*32 +: 32];
            outstanding = count;
        end
    end

    // Outstanding-transaction queue; a full queue blocks the push even if a pop happens.
    always_ff @(posedge clk) begin
        if (accept)
            q_mem[tail] <= grant;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (accept)
                tail <= tail + PW'(1);
            if (pop)
                head <= head + PW'(1);
            case ({accept, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (!resetn)
            rr_ptr <= '0;
        else if (accept)
            rr_ptr <= (grant == IDW'(NCH - 1)) ? '0 : grant + IDW'(1);
    end
`endif

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Randomized + directed bench for sram_like_arbiter against a queue-based reference model.
module tb_sram_like_arbiter;
  localparam int NCH   = 2;
  localparam int DEPTH = 4;
  localparam int IDW   = ($clog2(NCH) > 1) ? $clog2(NCH) : 1;
  localparam int PW    = $clog2(DEPTH);

  // clock/reset
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [NCH-1:0]    m_req, m_wr, m_addr_ok, m_data_ok;
  logic [2*NCH-1:0]  m_size;
  logic [4*NCH-1:0]  m_wstrb;
  logic [32*NCH-1:0] m_addr, m_wdata;
  logic [31:0]       m_rdata, s_addr, s_wdata, s_rdata;
  logic              s_req, s_wr, s_addr_ok, s_data_ok;
  logic [1:0]        s_size;
  logic [3:0]        s_wstrb;
  logic [PW:0]       outstanding;

  sram_like_arbiter #(.NCH(NCH), .DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb),
    .s_addr(s_addr), .s_wdata(s_wdata),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
    .outstanding(outstanding)
  );

  // scoreboard / reference model state
  logic [IDW-1:0] exp_q[$];
  bit             mdl_lock;
  int             mdl_lock_ch;
  int             mdl_rr;
  logic [NCH-1:0] last_aok;
  int             n_cmp = 0;
  int             n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // driver tasks
  task automatic clear_inputs();
    m_req = '0; m_wr = '0; m_size = '0; m_wstrb = '0; m_addr = '0; m_wdata = '0;
    s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = '0;
  endtask

  task automatic set_chan(input int ch, input bit req, input logic [31:0] addr);
    m_req[ch]           = req;
    m_addr[ch*32 +: 32] = addr;
    m_wdata[ch*32 +: 32] = $urandom;
    m_wr[ch]            = 1'($urandom_range(0, 1));
    m_size[ch*2 +: 2]   = 2'($urandom_range(0, 2));
    m_wstrb[ch*4 +: 4]  = 4'($urandom_range(0, 15));
  endtask

  // One clock cycle: check combinational outputs against the model, then advance the model.
  task automatic step();
    int g;
    bit full, exp_sreq, acc, pop;
    logic [NCH-1:0] exp_aok, exp_dok;
    #1;
    if (!resetn) begin
      chk("rst_s_req", 32'(s_req), 0);
      chk("rst_addr_ok", 32'(m_addr_ok), 0);
      chk("rst_data_ok", 32'(m_data_ok), 0);
      chk("rst_rdata", m_rdata, 0);
      chk("rst_s_addr", s_addr, 0);
      chk("rst_outstanding", 32'(outstanding), 0);
      @(posedge clk);
      exp_q.delete();
      mdl_lock = 1'b0; mdl_lock_ch = 0; mdl_rr = 0; last_aok = '0;
      #1;
      return;
    end
    full = (exp_q.size() == DEPTH);
    g = -1;
    if (mdl_lock) g = mdl_lock_ch;
    else begin
`ifdef ARB_ROUND_ROBIN_EN
      for (int k = 0; k < NCH; k++)
        if (g < 0 && m_req[(mdl_rr + k) % NCH]) g = (mdl_rr + k) % NCH;
`else
      for (int i = NCH - 1; i >= 0; i--)
        if (g < 0 && m_req[i]) g = i;
`endif
    end
    exp_sreq = (g >= 0) && m_req[g] && !full;
    acc = exp_sreq && s_addr_ok;
    exp_aok = acc ? NCH'(1) << g : '0;
    pop = s_data_ok && exp_q.size() != 0;
    exp_dok = pop ? NCH'(1) << exp_q[0] : '0;
    chk("s_req", 32'(s_req), 32'(exp_sreq));
    chk("m_addr_ok", 32'(m_addr_ok), 32'(exp_aok));
    chk("m_data_ok", 32'(m_data_ok), 32'(exp_dok));
    chk("outstanding", 32'(outstanding), 32'(exp_q.size()));
    if (exp_sreq) begin
      chk("s_addr", s_addr, m_addr[g*32 +: 32]);
      chk("s_wdata", s_wdata, m_wdata[g*32 +: 32]);
      chk("s_ctrl", {25'd0, s_wr, s_size, s_wstrb},
          {25'd0, m_wr[g], m_size[g*2 +: 2], m_wstrb[g*4 +: 4]});
    end
    if (pop) chk("m_rdata", m_rdata, s_rdata);
    @(posedge clk);
    if (pop) void'(exp_q.pop_front());
    if (acc) begin
      exp_q.push_back(IDW'(g));
      mdl_rr = (g + 1) % NCH;
    end
    mdl_lock = exp_sreq && !s_addr_ok;
    if (mdl_lock) mdl_lock_ch = g;
    last_aok = exp_aok;
    #1;
  endtask

  task automatic drain();
    clear_inputs();
    s_data_ok = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      s_rdata = $urandom;
      step();
    end
    s_data_ok = 1'b0;
  endtask

  initial begin
    clear_inputs();
    mdl_lock = 1'b0; mdl_lock_ch = 0; mdl_rr = 0; last_aok = '0;
    resetn = 1'b0;
    set_chan(0, 1, 32'h100); set_chan(1, 1, 32'h200);
    s_addr_ok = 1'b1; s_data_ok = 1'b1; s_rdata = 32'hdead;
    step(); step();
    clear_inputs();
    resetn = 1'b1;
    step();

    // back-to-back, both channels requesting
    set_chan(0, 1, 32'h1000); set_chan(1, 1, 32'h2000);
    s_addr_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
`ifndef ARB_ROUND_ROBIN_EN
      chk("b2b_grant", 32'(m_addr_ok), 32'h2);
`endif
      step();
    end
    clear_inputs();
    s_data_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_rdata = $urandom;
      #1;
`ifndef ARB_ROUND_ROBIN_EN
      chk("b2b_resp", 32'(m_data_ok), 32'h2);
`endif
      chk("b2b_rdata", m_rdata, s_rdata);
      step();
    end
    clear_inputs();

    // lock: channel 0 pending, channel 1 joins in cycle 2
    set_chan(0, 1, 32'h0000_0a00);
    step();
    set_chan(1, 1, 32'h0000_0b00);
    #1; chk("lock_addr", s_addr, 32'h0000_0a00);
    step();
    #1; chk("lock_addr", s_addr, 32'h0000_0a00);
    step();
    s_addr_ok = 1'b1;
    #1; chk("lock_release", 32'(m_addr_ok), 32'h1);
    step();
    m_req[0] = 1'b0;
    step();
    drain();

    // full queue
    set_chan(1, 1, 32'h3000);
    s_addr_ok = 1'b1;
    for (int i = 0; i < DEPTH; i++) step();
    #1;
    chk("full_count", 32'(outstanding), DEPTH);
    chk("full_sreq", 32'(s_req), 0);
    s_data_ok = 1'b1; s_rdata = 32'h55;
    #1; chk("full_pop_sreq", 32'(s_req), 0);
    step();
    s_data_ok = 1'b0;
    #1;
    chk("full_next_sreq", 32'(s_req), 1);
    chk("full_next_aok", 32'(m_addr_ok), 32'h2);
    step();
    drain();

    // interleaved ordering ch1, ch0, ch1
    s_addr_ok = 1'b1;
    set_chan(1, 1, 32'h11); step();
    m_req = '0; set_chan(0, 1, 32'h22); step();
    m_req = '0; set_chan(1, 1, 32'h33); step();
    clear_inputs();
    step(); step();
    s_data_ok = 1'b1;
    s_rdata = 32'hA; #1; chk("ilv_dok0", 32'(m_data_ok), 32'h2); chk("ilv_rd0", m_rdata, 32'hA); step();
    s_rdata = 32'hB; #1; chk("ilv_dok1", 32'(m_data_ok), 32'h1); chk("ilv_rd1", m_rdata, 32'hB); step();
    s_rdata = 32'hC; #1; chk("ilv_dok2", 32'(m_data_ok), 32'h2); chk("ilv_rd2", m_rdata, 32'hC); step();

    // spurious response on an empty queue
    s_rdata = 32'h77;
    #1;
    chk("spur_dok", 32'(m_data_ok), 0);
    chk("spur_cnt", 32'(outstanding), 0);
    step();
    clear_inputs();

    // reset with two outstanding
    s_addr_ok = 1'b1;
    set_chan(0, 1, 32'h44); step(); step();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    clear_inputs();
    #1; chk("post_rst_cnt", 32'(outstanding), 0);
    s_data_ok = 1'b1;
    #1; chk("post_rst_spur", 32'(m_data_ok), 0);
    step();
    clear_inputs();

    // randomized traffic; masters hold a pending request until accepted
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int ch = 0; ch < NCH; ch++)
        if (!m_req[ch] || last_aok[ch])
          set_chan(ch, ($urandom_range(0, 2) != 0), $urandom);
      s_addr_ok = ($urandom_range(0, 3) != 0);
      s_data_ok = ($urandom_range(0, 2) == 0);
      s_rdata   = $urandom;
      if (cyc % 700 == 699) resetn = 1'b0;
      step();
      resetn = 1'b1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
